// File: rtl/axi4s_pkt_arbiter.sv
// Packet-granular round-robin arbiter: NUM_PORTS AXI4-Stream sources onto one 64-bit
// output, each granted packet prefixed by a {length, port id} header beat.
//   state | meaning
//   IDLE  | choose next eligible port after last_grant, latch its declared length
//   HDR   | present header beat until accepted
//   DATA  | pass-through of granted port, count bytes until tlast handshake
//   GAP   | forced idle for the configured number of cycles
module axi4s_pkt_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int LEN_W     = 16,
  parameter int GAP_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_PORTS-1:0]       cfg_port_en,
  input  logic [GAP_W-1:0]           cfg_idle_cycles,
  input  logic [NUM_PORTS*64-1:0]    s_tdata,
  input  logic [NUM_PORTS*8-1:0]     s_tkeep,
  input  logic [NUM_PORTS-1:0]       s_tlast,
  input  logic [NUM_PORTS-1:0]       s_tvalid,
  output logic [NUM_PORTS-1:0]       s_tready,
  input  logic [NUM_PORTS*LEN_W-1:0] s_len,
  output logic [63:0]                m_tdata,
  output logic [7:0]                 m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       len_err,
  output logic [31:0]                pkt_count,
  output logic                       busy
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [PW-1:0]    last_grant_q, last_grant_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             len_err_q, len_err_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;

  logic [63:0]      data_a [NUM_PORTS];
  logic [7:0]       keep_a [NUM_PORTS];
  logic [LEN_W-1:0] len_a  [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      data_a[i] = s_tdata[i*64 +: 64];
      keep_a[i] = s_tkeep[i*8 +: 8];
      len_a[i]  = s_len[i*LEN_W +: LEN_W];
    end
  end

  assign elig = s_tvalid & cfg_port_en;

  // Lowest eligible index above last_grant wins; otherwise wrap to lowest eligible overall.
  logic          hi_found;
  logic [PW-1:0] hi_pick, lo_pick, pick;

  always_comb begin
    hi_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_pick = PW'(i);
        if (i > int'(last_grant_q)) begin
          hi_found = 1'b1;
          hi_pick  = PW'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : lo_pick;
  end

  logic [3:0]       beat_bytes;
  logic [LEN_W+1:0] cnt_sum_w;
  logic [LEN_W:0]   cnt_sum;

  always_comb begin
    beat_bytes = 4'($countones(keep_a[grant_q]));
    cnt_sum_w  = {1'b0, cnt_q} + (LEN_W+2)'(beat_bytes);
    cnt_sum    = cnt_sum_w[LEN_W+1] ? '1 : cnt_sum_w[LEN_W:0];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    pkt_cnt_d    = pkt_cnt_q;
    len_err_d    = 1'b0;
    m_tdata      = '0;
    m_tkeep      = '0;
    m_tlast      = 1'b0;
    m_tvalid     = 1'b0;
    s_tready     = '0;

    case (state_q)
      IDLE: begin
        if (|elig) begin
          grant_d = pick;
          len_d   = len_a[pick];
          cnt_d   = '0;
          state_d = HDR;
        end
      end

      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {16'(len_q), 16'(grant_q), 32'h0};
        m_tkeep  = 8'hF0;
        if (m_tready) begin
          state_d = DATA;
        end
      end

      DATA: begin
        m_tdata            = data_a[grant_q];
        m_tkeep            = keep_a[grant_q];
        m_tlast            = s_tlast[grant_q];
        m_tvalid           = s_tvalid[grant_q];
        s_tready[grant_q]  = m_tready;
        if (m_tvalid && m_tready) begin
          cnt_d = cnt_sum;
          if (m_tlast) begin
            last_grant_d = grant_q;
            pkt_cnt_d    = pkt_cnt_q + 32'd1;
            len_err_d    = (cnt_sum != {1'b0, len_q});
            if (cfg_idle_cycles != '0) begin
              gap_d   = cfg_idle_cycles;
              state_d = GAP;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      GAP: begin
        if (gap_q == GAP_W'(1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= PW'(NUM_PORTS - 1);
      len_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      len_err_q    <= 1'b0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      len_err_q    <= len_err_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  assign len_err   = len_err_q;
  assign pkt_count = pkt_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule
